// File: rtl/vga_timing_shift.sv
// VGA raster timing generator with a frame-divided scroll strobe (en_shift).
// Optional macro SHIFT_FREEZE_EN adds a shift_freeze input that suppresses the strobe.
module vga_timing_shift #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned SHIFT_DIV = 1,
    parameter int unsigned XY_W      = 10
) (
    input  logic            pixel_clk,
    input  logic            reset_n,
`ifdef SHIFT_FREEZE_EN
    input  logic            shift_freeze,
`endif
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [XY_W-1:0] pix_x,
    output logic [XY_W-1:0] pix_y,
    output logic            frame_start,
    output logic            en_shift
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_TOTAL - 1);
    localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_TOTAL - 1);
    localparam logic [XY_W-1:0] H_ACT_C  = XY_W'(H_ACTIVE);
    localparam logic [XY_W-1:0] V_ACT_C  = XY_W'(V_ACTIVE);
    localparam logic [XY_W-1:0] HS_START = XY_W'(H_ACTIVE + H_FP);
    localparam logic [XY_W-1:0] HS_END   = XY_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XY_W-1:0] VS_START = XY_W'(V_ACTIVE + V_FP);
    localparam logic [XY_W-1:0] VS_END   = XY_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0]      DIV_LAST = 8'(SHIFT_DIV - 1);

    logic [XY_W-1:0] h_q, h_d, v_q, v_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            de_d, hsync_d, vsync_d, fs_d, en_d;
    logic            shift_slot, shift_go;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Outputs are decoded from the next-state counters so they line up with h_q/v_q.
    always_comb begin
        de_d       = (h_d < H_ACT_C) && (v_d < V_ACT_C);
        hsync_d    = !((h_d >= HS_START) && (h_d < HS_END));
        vsync_d    = !((v_d >= VS_START) && (v_d < VS_END));
        fs_d       = (h_d == '0) && (v_d == '0);
        shift_slot = (h_d == '0) && (v_d == V_ACT_C);
`ifdef SHIFT_FREEZE_EN
        shift_go   = shift_slot && !shift_freeze;
`else
        shift_go   = shift_slot;
`endif
        fcnt_d     = fcnt_q;
        en_d       = 1'b0;
        if (shift_go) begin
            en_d   = (fcnt_q == DIV_LAST);
            fcnt_d = en_d ? 8'd0 : fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q         <= H_LAST;
            v_q         <= V_LAST;
            fcnt_q      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            en_shift    <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            fcnt_q      <= fcnt_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            de          <= de_d;
            pix_x       <= de_d ? h_d : '0;
            pix_y       <= de_d ? v_d : '0;
            frame_start <= fs_d;
            en_shift    <= en_d;
        end
    end

endmodule

// File: doc/vga_timing_shift.md
Name: vga_timing_shift

Overview:
- Generates 640x480@60 VGA raster timing on the 25 MHz pixel clock: sync signals, data enable and pixel coordinates.
- Produces the one-cycle en_shift strobe that advances the waveform generator's scroll once every SHIFT_DIV frames, during vertical blanking.
- Sits directly upstream of the parabola/waveform generator and the pixel compositor; its syncs also drive the VGA DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SHIFT_DIV, 1, frames per en_shift pulse; legal range 1..255
- XY_W, 10, width of pix_x/pix_y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pixel_clk  in  1  pixel clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  high while the current position is visible
- pix_x  out  XY_W  column of current position, 0 when de=0
- pix_y  out  XY_W  line of current position, 0 when de=0
- frame_start  out  1  one-cycle pulse at position (0,0)
- en_shift  out  1  one-cycle scroll strobe to the waveform generator

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal h counter runs 0..H_TOTAL-1 and wraps to 0. v counter advances only on h wrap, runs 0..V_TOTAL-1 and wraps to 0.
- Reset (async, reset_n=0):
  - h=H_TOTAL-1, v=V_TOTAL-1, frame counter fcnt=0.
  - Outputs: hsync=1, vsync=1, de=0, pix_x=0, pix_y=0, frame_start=0, en_shift=0.
- The first rising edge after reset release presents position (0,0). Reset mid-frame aborts the frame immediately; there is no partial-pulse carry-over.
- All outputs are registered and decoded from the next-state counters. Outputs sampled in a cycle describe the position held in h/v that cycle, with zero latency relative to the counters.
- de = (h < H_ACTIVE) and (v < V_ACTIVE).
- pix_x = h and pix_y = v when de=1; both are 0 otherwise.
- hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- frame_start=1 only at (h,v)=(0,0).
- Frame counter fcnt:
  - Increments at position (0,V_ACTIVE), the first cycle of vertical blanking.
  - Wraps SHIFT_DIV-1 -> 0.
  - en_shift=1 at exactly (0,V_ACTIVE) when fcnt==SHIFT_DIV-1 before the increment.
  - Result: one pulse per SHIFT_DIV frames, never during active video.
- SHIFT_DIV=1: en_shift pulses every frame. The first pulse after reset occurs in frame 0 at (0,V_ACTIVE).
- Exactly one en_shift per qualifying frame; en_shift and frame_start never coincide.

Optional Feature:
- Macro: SHIFT_FREEZE_EN.
- Defined:
  - Adds input port shift_freeze (1 bit, after reset_n in the port list).
  - While shift_freeze=1 at the qualifying cycle (0,V_ACTIVE), en_shift stays 0 and fcnt holds its value.
  - Freezing never affects syncs, de or coordinates.
  - Sampled only at (0,V_ACTIVE); toggling it elsewhere has no effect.
- Not defined: no shift_freeze port; behaviour as above with scrolling always running.

Test Plan:
- Small timing (H 8/2/2/2 -> H_TOTAL=14; V 4/1/1/1 -> V_TOTAL=7; SHIFT_DIV=2):
  - Release reset -> first edge shows de=1, pix_x=0, pix_y=0, frame_start=1.
  - hsync low at h=10,11 every line.
  - vsync low for all 14 cycles of line v=5.
  - Frame period = 98 cycles.
- Same config, run 6 frames:
  - en_shift pulses exactly 3 times, each at (0,4).
  - Pulses fall in frames 1, 3, 5 (fcnt wraps 1->0).
  - Each pulse is 1 cycle wide; de=0 during every pulse.
- Same config, check de and coordinates:
  - de high 8 of 14 cycles on lines 0..3 and 0 cycles on lines 4..6 -> 32 de cycles per frame.
  - pix_x/pix_y = 0 whenever de=0.
- Default 640x480:
  - Frame = 420000 cycles.
  - hsync low 96 cycles starting at h=656.
  - vsync low on lines 490-491.
  - With SHIFT_DIV=1: en_shift at cycle 480*800=384000 after frame_start.
- Assert reset_n=0 mid-line (h=300, v=100) for 3 cycles:
  - Outputs take reset values asynchronously.
  - After release, (0,0) with frame_start=1 on the first edge.
  - Next en_shift arrives 384000 cycles later.
- With SHIFT_FREEZE_EN, SHIFT_DIV=1, shift_freeze=1 during frames 1-2:
  - en_shift in frames 0, 3, 4 only.
  - Syncs and de are identical to the unfrozen run.
